bmp_stream_unpacker: RTL and testbench

//  Byte-stream BMP decoder: accepts a raw 24-bit BMP file one byte per handshake, parses the header,

---
 rtl/bmp_stream_unpacker_pkg.sv | 32 +++
 rtl/bmp_stream_unpacker_hdr_capture.sv | 83 ++++++++
 rtl/bmp_stream_unpacker.sv | 172 +++++++++++++++++
 tb/tb_bmp_stream_unpacker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_stream_unpacker_pkg.sv
// Shared constants for the BMP byte-stream unpacker: header offsets, limits,
// FSM state encoding and error codes.
package bmp_stream_unpacker_pkg;

  localparam int BMP_CNT_W     = 32;
  localparam int BMP_MAX_BYTES = 512000;

  // Absolute byte offsets of the little-endian header fields.
  localparam int OFF_SIZE     = 2;
  localparam int OFF_START    = 10;
  localparam int OFF_WIDTH    = 18;
  localparam int OFF_HEIGHT   = 22;
  localparam int OFF_BPP      = 28;
  localparam int OFF_HDR_LAST = 29;
  localparam int MIN_START    = 30;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_CHECK = 3'd1,
    S_SKIP  = 3'd2,
    S_PIX   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_BPP   = 3'd1;
  localparam logic [2:0] ERR_WIDTH = 3'd2;
  localparam logic [2:0] ERR_START = 3'd3;
  localparam logic [2:0] ERR_SIZE  = 3'd4;

endpackage

// File: rtl/bmp_stream_unpacker_hdr_capture.sv
// Byte counter plus little-endian capture of the BMP header fields, keyed on
// the absolute offset of each accepted byte.
module bmp_stream_unpacker_hdr_capture
  import bmp_stream_unpacker_pkg::*;
#(
  parameter int CNT_W = BMP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             accept_i,
  input  logic [7:0]       byte_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] size_o,
  output logic [CNT_W-1:0] start_o,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] height_o,
  output logic [15:0]      bpp_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] size_q, size_d;
  logic [CNT_W-1:0] start_q, start_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] height_q, height_d;
  logic [15:0]      bpp_q, bpp_d;

  function automatic logic hit(input logic [CNT_W-1:0] c, input int base, input int len);
    return (c >= CNT_W'(base)) && (c < CNT_W'(base + len));
  endfunction

  // Bytes arrive LSB first, so shifting each one in from the top leaves the
  // field correctly ordered once all of its bytes have been seen.
  always_comb begin
    cnt_d    = cnt_q;
    size_d   = size_q;
    start_d  = start_q;
    width_d  = width_q;
    height_d = height_q;
    bpp_d    = bpp_q;
    if (clear_i) begin
      cnt_d    = '0;
      size_d   = '0;
      start_d  = '0;
      width_d  = '0;
      height_d = '0;
      bpp_d    = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + 1'b1;
      if (hit(cnt_q, OFF_SIZE, 4))   size_d   = {byte_i, size_q[CNT_W-1:8]};
      if (hit(cnt_q, OFF_START, 4))  start_d  = {byte_i, start_q[CNT_W-1:8]};
      if (hit(cnt_q, OFF_WIDTH, 4))  width_d  = {byte_i, width_q[CNT_W-1:8]};
      if (hit(cnt_q, OFF_HEIGHT, 4)) height_d = {byte_i, height_q[CNT_W-1:8]};
      if (hit(cnt_q, OFF_BPP, 2))    bpp_d    = {byte_i, bpp_q[15:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      size_q   <= '0;
      start_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
      bpp_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      start_q  <= start_d;
      width_q  <= width_d;
      height_q <= height_d;
      bpp_q    <= bpp_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign size_o   = size_q;
  assign start_o  = start_q;
  assign width_o  = width_q;
  assign height_o = height_q;
  assign bpp_o    = bpp_q;

endmodule

// File: rtl/bmp_stream_unpacker.sv
// 24-bit BMP byte-stream decoder: parses the header, skips to pixel data and
// emits one B/G/R triple per done_o strobe.
module bmp_stream_unpacker
  import bmp_stream_unpacker_pkg::*;
#(
  parameter int MAX_BYTES = BMP_MAX_BYTES,
  parameter int CNT_W     = BMP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic [7:0]       red_o,
  output logic [7:0]       green_o,
  output logic [7:0]       blue_o,
  output logic             done_o,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] height_o,
  output logic             hdr_valid_o,
  output logic             frame_done_o,
  output logic [2:0]       error_o,
  output logic [2:0]       dbg_state_o
);

  // Handshake: a byte transfers on a posedge where byte_valid_i and
  // byte_ready_o are both high; byte_i must stay stable while valid is high
  // and ready is low. done_o has no backpressure.
  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       b_q, b_d, g_q, g_d;
  logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             done_q, done_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [2:0]       error_q, error_d;
  logic             clear;
  logic             accept;
  logic [CNT_W-1:0] cnt, size, start_pos, width, height, data_len;
  logic [15:0]      bpp;

  assign byte_ready_o = (state_q == S_HDR) || (state_q == S_SKIP) || (state_q == S_PIX);
  assign accept       = byte_valid_i && byte_ready_o;
  assign data_len     = size - start_pos;

  bmp_stream_unpacker_hdr_capture #(.CNT_W(CNT_W)) u_hdr (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .accept_i (accept),
    .byte_i   (byte_i),
    .cnt_o    (cnt),
    .size_o   (size),
    .start_o  (start_pos),
    .width_o  (width),
    .height_o (height),
    .bpp_o    (bpp)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    b_d          = b_q;
    g_d          = g_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    done_d       = 1'b0;
    hdr_valid_d  = hdr_valid_q;
    frame_done_d = frame_done_q;
    error_d      = error_q;
    clear        = 1'b0;
    case (state_q)
      S_HDR: begin
        if (accept && cnt == CNT_W'(OFF_HDR_LAST)) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_ERR;
        if (bpp != 16'd24)                      error_d = ERR_BPP;
        else if (width[1:0] != 2'b00)           error_d = ERR_WIDTH;
        else if (start_pos < CNT_W'(MIN_START)) error_d = ERR_START;
        else if (size <= start_pos || size > CNT_W'(MAX_BYTES) ||
                 (data_len % CNT_W'(3)) != '0)  error_d = ERR_SIZE;
        else begin
          hdr_valid_d = 1'b1;
          state_d     = (start_pos == CNT_W'(MIN_START)) ? S_PIX : S_SKIP;
        end
      end
      S_SKIP: begin
        if (accept && cnt == start_pos - 1'b1) state_d = S_PIX;
      end
      S_PIX: begin
        if (accept) begin
          case (phase_q)
            2'd0: begin
              b_d     = byte_i;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = byte_i;
              phase_d = 2'd2;
            end
            default: begin
              red_d   = byte_i;
              green_d = g_q;
              blue_d  = b_q;
              done_d  = 1'b1;
              phase_d = 2'd0;
            end
          endcase
          // Data length is a multiple of 3, so the last byte is always an R byte.
          if (cnt == size - 1'b1) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_d      = S_HDR;
          phase_d      = 2'd0;
          hdr_valid_d  = 1'b0;
          frame_done_d = 1'b0;
          error_d      = ERR_NONE;
          clear        = 1'b1;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      phase_q      <= 2'd0;
      b_q          <= '0;
      g_q          <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      done_q       <= 1'b0;
      hdr_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      b_q          <= b_d;
      g_q          <= g_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      done_q       <= done_d;
      hdr_valid_q  <= hdr_valid_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;
    end
  end

  assign red_o        = red_q;
  assign green_o      = green_q;
  assign blue_o       = blue_q;
  assign done_o       = done_q;
  assign width_o      = width;
  assign height_o     = height;
  assign hdr_valid_o  = hdr_valid_q;
  assign frame_done_o = frame_done_q;
  assign error_o      = error_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_bmp_stream_unpacker.sv
// Bench for bmp_stream_unpacker: table of header cases, hand-written reset and
// restart sequences, and randomized files checked against a byte-array model.
module tb_bmp_stream_unpacker;
  import bmp_stream_unpacker_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [7:0]  red_o, green_o, blue_o;
  logic        done_o;
  logic [31:0] width_o, height_o;
  logic        hdr_valid_o, frame_done_o;
  logic [2:0]  error_o;
  logic [2:0]  dbg_state_o;

  bmp_stream_unpacker dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .red_o        (red_o),
    .green_o      (green_o),
    .blue_o       (blue_o),
    .done_o       (done_o),
    .width_o      (width_o),
    .height_o     (height_o),
    .hdr_valid_o  (hdr_valid_o),
    .frame_done_o (frame_done_o),
    .error_o      (error_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pix_cnt  = 0;
  logic        prev_done = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_pix;
  logic [7:0]  file [0:255];

  typedef struct {
    int size;
    int start;
    int width;
    int height;
    int bpp;
    int gap;
    int exp_err;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_valid_i = 1'b0;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pix_cnt = 0;
  endtask

  task automatic check_reset_state();
    check("rst_pixel", {8'h0, red_o, green_o, blue_o}, 32'h0);
    check("rst_flags", {26'h0, done_o, hdr_valid_o, frame_done_o, error_o}, 32'h0);
    check("rst_width", width_o, 32'h0);
    check("rst_height", height_o, 32'h0);
    check("rst_ready", 32'(byte_ready_o), 32'h1);
  endtask

  // ---------------- reference model ----------------
  task automatic put_le(input int off, input int val, input int n);
    for (int j = 0; j < n; j++) file[off + j] = 8'(val >> (8 * j));
  endtask

  task automatic build_file(input int size, input int start, input int w, input int h,
                            input int bpp, input bit ramp);
    for (int i = 0; i < 256; i++) file[i] = 8'h00;
    file[0] = 8'h42;
    file[1] = 8'h4D;
    put_le(OFF_SIZE, size, 4);
    put_le(OFF_START, start, 4);
    put_le(OFF_WIDTH, w, 4);
    put_le(OFF_HEIGHT, h, 4);
    put_le(OFF_BPP, bpp, 2);
    for (int i = 30; i < start && i < 256; i++) file[i] = 8'($urandom_range(255));
    for (int i = (start > 30 ? start : 30); i < size && i < 256; i++)
      file[i] = ramp ? 8'(i - start) : 8'($urandom_range(255));
  endtask

  function automatic longint le(input int off, input int n);
    longint v = 0;
    for (int j = n - 1; j >= 0; j--) v = v * 256 + longint'(file[off + j]);
    return v;
  endfunction

  function automatic int model_err();
    longint sz  = le(OFF_SIZE, 4);
    longint st  = le(OFF_START, 4);
    longint w   = le(OFF_WIDTH, 4);
    longint bpp = le(OFF_BPP, 2);
    if (bpp != 24) return 1;
    if (w % 4 != 0) return 2;
    if (st < 30) return 3;
    if (sz <= st || sz > BMP_MAX_BYTES || (sz - st) % 3 != 0) return 4;
    return 0;
  endfunction

  task automatic model_pixels(input int size, input int start);
    for (int k = 0; k < (size - start) / 3; k++)
      exp_q.push_back({file[start + 3*k + 2], file[start + 3*k + 1], file[start + 3*k]});
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    while (int'($urandom_range(99)) < gap) begin
      byte_valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (byte_ready_o) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic send_file(input int n, input int gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      send_byte(file[i], gap, ok);
      if (!ok) begin
        check("byte_accept", 32'(i), 32'(n));
        return;
      end
    end
  endtask

  task automatic run_file(input int size, input int start, input int w, input int h,
                          input int gap, input int exp_err);
    pix_cnt = 0;
    if (exp_err == 0) begin
      model_pixels(size, start);
      send_file(size, gap);
      for (int c = 0; c < 300 && !frame_done_o; c++) @(negedge clk);
      @(posedge clk);
      #1;
      check("frame_done", 32'(frame_done_o), 32'h1);
      check("pixel_count", 32'(pix_cnt), 32'((size - start) / 3));
      check("exp_q_drained", 32'(exp_q.size()), 32'h0);
      check("hdr_valid", 32'(hdr_valid_o), 32'h1);
      check("width", width_o, 32'(w));
      check("height", height_o, 32'(h));
    end else begin
      send_file(30, gap);
      repeat (3) @(posedge clk);
      #1;
      check("hdr_valid_err", 32'(hdr_valid_o), 32'h0);
      check("no_pixels", 32'(pix_cnt), 32'h0);
      check("frame_done_err", 32'(frame_done_o), 32'h0);
    end
    check("error_code", 32'(error_o), 32'(exp_err));
    check("ready_after", 32'(byte_ready_o), 32'h0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        pix_cnt++;
        check("done_spacing", 32'(prev_done), 32'h0);
        check("done_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          exp_pix = exp_q.pop_front();
          check("pixel_rgb", {8'h0, red_o, green_o, blue_o}, {8'h0, exp_pix});
          check("frame_done_on_last", 32'(frame_done_o), 32'(exp_q.size() == 0));
        end
      end
      prev_done = done_o;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    byte_i = 8'h00;
    byte_valid_i = 1'b0;

    vecs[0] = '{78, 54, 4, 2, 24, 0, 0};
    vecs[1] = '{78, 54, 4, 2, 8, 0, 1};
    vecs[2] = '{78, 54, 6, 2, 24, 0, 2};
    vecs[3] = '{77, 54, 4, 2, 24, 0, 4};
    vecs[4] = '{78, 20, 4, 2, 24, 0, 3};
    vecs[5] = '{600000, 54, 4, 2, 24, 0, 4};
    vecs[6] = '{54, 54, 4, 2, 24, 0, 4};
    vecs[7] = '{78, 54, 4, 2, 24, 50, 0};

    do_reset();
    check_reset_state();

    for (int v = 0; v < 8; v++) begin
      do_reset();
      build_file(vecs[v].size, vecs[v].start, vecs[v].width, vecs[v].height, vecs[v].bpp, 1'b1);
      run_file(vecs[v].size, vecs[v].start, vecs[v].width, vecs[v].height,
               vecs[v].gap, vecs[v].exp_err);
      if (v == 0) check("last_pixel", {8'h0, red_o, green_o, blue_o}, 32'h00171615);
    end

    // Reset after one full pixel plus one B byte.
    do_reset();
    build_file(78, 54, 4, 2, 24, 1'b1);
    model_pixels(78, 54);
    send_file(58, 0);
    @(negedge clk);
    check("pixels_before_rst", 32'(pix_cnt), 32'h1);
    @(posedge clk);
    #1;
    do_reset();
    check_reset_state();
    run_file(78, 54, 4, 2, 0, 0);

    // start_i ignored while streaming, honoured in S_DONE.
    do_reset();
    build_file(78, 54, 4, 2, 24, 1'b1);
    model_pixels(78, 54);
    send_file(40, 0);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("start_ignored", 32'(hdr_valid_o), 32'h1);
    for (int i = 40; i < 78; i++) begin
      bit ok;
      send_byte(file[i], 0, ok);
    end
    repeat (2) @(posedge clk);
    #1;
    check("frame_after_ignored_start", {30'h0, frame_done_o, 1'b0} | 32'(pix_cnt << 2), 32'h22);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("restart_flags", {28'h0, hdr_valid_o, frame_done_o, error_o != 3'd0, byte_ready_o}, 32'h1);
    build_file(78, 60, 4, 2, 24, 1'b1);
    run_file(78, 60, 4, 2, 0, 0);

    // Randomized files, some with header errors, with random valid gaps.
    for (int r = 0; r < 10; r++) begin
      int sel, bpp, w, h, st, sz, gap, err;
      sel = int'($urandom_range(9));
      bpp = (sel == 0) ? 16 : 24;
      w   = (sel == 1) ? 6 : 4 * int'($urandom_range(1, 2));
      h   = int'($urandom_range(1, 3));
      st  = int'($urandom_range(30, 60));
      sz  = st + 3 * w * h + ((sel == 2) ? 1 : 0);
      gap = int'($urandom_range(0, 50));
      do_reset();
      build_file(sz, st, w, h, bpp, 1'b0);
      err = model_err();
      run_file(sz, st, w, h, gap, err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
